// File: rtl/anemo_pio_poller.sv
// rtl/anemo_pio_poller.sv - periodic Avalon-MM PIO poller feeding a FWFT sample FIFO
module anemo_pio_poller #(
  parameter int POLL_PERIOD = 1000,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int CNT_W = $clog2(POLL_PERIOD);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_tc;
  logic                  w_start;

  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_first;
  logic [DATA_WIDTH-1:0] w_sample;
  logic                  w_capt;
  logic                  w_push;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;

  // Only the low DATA_WIDTH bits of readdata carry the PIO value.
  logic                  w_unused;
  assign w_unused = ^avm_readdata;

  assign w_tc    = (r_cnt == CNT_LAST);
  assign w_start = enable && w_tc && (r_state == S_IDLE);

  // Period counter: free-runs while enabled, parked at 0 when disabled, wraps at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!enable || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: a started read always runs READ -> CAPT -> IDLE, even if enable drops.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_READ;
      S_READ:  w_next_state = S_CAPT;
      S_CAPT:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: read strobe is a pure decode of the state so reset drops it immediately.
  always_comb begin
    avm_read = 1'b0;
    if (r_state == S_READ) avm_read = 1'b1;
  end

  assign avm_address = 2'b00;

  assign w_capt   = (r_state == S_CAPT);
  assign w_sample = avm_readdata[DATA_WIDTH-1:0];
  assign w_push   = w_capt && (!CHANGE_ONLY || r_first || (w_sample != r_last));

  // Change filter history: every completed read updates last, whether or not it was queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= '0;
      r_first <= 1'b1;
    end else if (w_capt) begin
      r_last  <= w_sample;
      r_first <= 1'b0;
    end
  end

  assign sample_valid = (r_occ != '0);
  assign w_full       = (r_occ == OCC_FULL);
  assign w_pop        = sample_valid && sample_ready;
  assign w_wr         = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && w_full && !w_pop;
  assign sample_data  = sample_valid ? r_mem[r_rd_ptr] : '0;

  // FIFO storage: no reset needed, occupancy gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_sample;
  end

  // FIFO pointers and occupancy; a push into a full FIFO is accepted only alongside a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle wins over a clear request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (w_drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anemo_pio_poller.sv
// tb/tb_anemo_pio_poller.sv - self-checking bench for anemo_pio_poller
module tb_anemo_pio_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'h0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overflow;
  logic        clear_overflow = 1'b0;
  logic [31:0] slave_val = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  anemo_pio_poller #(
    .POLL_PERIOD(4),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .CHANGE_ONLY(1'b1)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .avm_address   (avm_address),
    .avm_read      (avm_read),
    .avm_readdata  (avm_readdata),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // PIO slave with read latency 1; data bus carries junk when not answering a read.
  always @(posedge clk) begin
    avm_readdata <= avm_read ? slave_val : 32'hC3C3_C35A;
  end

  typedef struct {
    logic        en;
    logic        rdy;
    logic        clr;
    logic [31:0] sv;
    logic        exp_rd;
    logic        exp_vld;
    logic [7:0]  exp_dat;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic rdy, input logic clr, input logic [31:0] sv,
                     input logic rd, input logic vld, input logic [7:0] dat, input logic ovf);
    vec_t v;
    v.en = en; v.rdy = rdy; v.clr = clr; v.sv = sv;
    v.exp_rd = rd; v.exp_vld = vld; v.exp_dat = dat; v.exp_ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(input string tag);
    int n;
    n = 0;
    while (!avm_read && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".read_seen"}, {31'b0, avm_read}, 32'd1);
  endtask

  task automatic do_poll(input logic [31:0] v, input string tag);
    slave_val = v;
    wait_read(tag);
    step();
    step();
  endtask

  initial begin
    int nr;
    int n;

    // Test 1: constant 0xA5, only the first capture is queued.
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 0,0,8'h00,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 1,0,8'h00,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 0,1,8'hA5,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 1,0,8'h00,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 0,0,8'h00,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 1,0,8'h00,0);
    add(1,1,0,32'hA5, 0,0,8'h00,0); add(1,1,0,32'hA5, 0,0,8'h00,0);
    // Test 2: 0x12, 0x12, 0x34 with upper bits set.
    add(1,1,0,32'hFFFFFF12, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF12, 1,0,8'h00,0);
    add(1,1,0,32'hFFFFFF12, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF12, 0,1,8'h12,0);
    add(1,1,0,32'hFFFFFF12, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF12, 1,0,8'h00,0);
    add(1,1,0,32'hFFFFFF12, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF12, 0,0,8'h00,0);
    add(1,1,0,32'hFFFFFF34, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF34, 1,0,8'h00,0);
    add(1,1,0,32'hFFFFFF34, 0,0,8'h00,0); add(1,1,0,32'hFFFFFF34, 0,1,8'h34,0);
    add(1,1,0,32'hFFFFFF34, 0,0,8'h00,0);
    // Test 3: consumer stalled, six polls 1..6, FIFO fills with 1..4 then overflows.
    add(1,0,0,32'd1, 1,0,8'h00,0); add(1,0,0,32'd1, 0,0,8'h00,0);
    add(1,0,0,32'd1, 0,1,8'h01,0); add(1,0,0,32'd1, 0,1,8'h01,0);
    add(1,0,0,32'd2, 1,1,8'h01,0); add(1,0,0,32'd2, 0,1,8'h01,0);
    add(1,0,0,32'd2, 0,1,8'h01,0); add(1,0,0,32'd2, 0,1,8'h01,0);
    add(1,0,0,32'd3, 1,1,8'h01,0); add(1,0,0,32'd3, 0,1,8'h01,0);
    add(1,0,0,32'd3, 0,1,8'h01,0); add(1,0,0,32'd3, 0,1,8'h01,0);
    add(1,0,0,32'd4, 1,1,8'h01,0); add(1,0,0,32'd4, 0,1,8'h01,0);
    add(1,0,0,32'd4, 0,1,8'h01,0); add(1,0,0,32'd4, 0,1,8'h01,0);
    add(1,0,0,32'd5, 1,1,8'h01,0); add(1,0,0,32'd5, 0,1,8'h01,0);
    add(1,0,0,32'd5, 0,1,8'h01,1); add(1,0,0,32'd5, 0,1,8'h01,1);
    add(1,0,0,32'd6, 1,1,8'h01,1); add(1,0,0,32'd6, 0,1,8'h01,1);
    add(1,0,0,32'd6, 0,1,8'h01,1);
    // Drain with polling stopped, then clear the sticky flag.
    add(0,1,0,32'd6, 0,1,8'h02,1); add(0,1,0,32'd6, 0,1,8'h03,1);
    add(0,1,0,32'd6, 0,1,8'h04,1); add(0,1,0,32'd6, 0,0,8'h00,1);
    add(0,1,1,32'd6, 0,0,8'h00,0);

    repeat (2) step();
    chk("rst.read", {31'b0, avm_read}, 32'd0);
    chk("rst.address", {30'b0, avm_address}, 32'd0);
    chk("rst.valid", {31'b0, sample_valid}, 32'd0);
    chk("rst.data", {24'b0, sample_data}, 32'd0);
    chk("rst.overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en;
      sample_ready = tbl[i].rdy;
      clear_overflow = tbl[i].clr;
      slave_val = tbl[i].sv;
      step();
      chk($sformatf("row%0d.read", i + 1), {31'b0, avm_read}, {31'b0, tbl[i].exp_rd});
      chk($sformatf("row%0d.address", i + 1), {30'b0, avm_address}, 32'd0);
      chk($sformatf("row%0d.valid", i + 1), {31'b0, sample_valid}, {31'b0, tbl[i].exp_vld});
      chk($sformatf("row%0d.overflow", i + 1), {31'b0, overflow}, {31'b0, tbl[i].exp_ovf});
      if (tbl[i].exp_vld)
        chk($sformatf("row%0d.data", i + 1), {24'b0, sample_data}, {24'b0, tbl[i].exp_dat});
    end
    clear_overflow = 1'b0;

    // Test 4a: capture into a full FIFO while the consumer pops in the same cycle.
    enable = 1'b1;
    sample_ready = 1'b0;
    do_poll(32'h71, "t4.p1");
    do_poll(32'h72, "t4.p2");
    do_poll(32'h73, "t4.p3");
    do_poll(32'h74, "t4.p4");
    chk("t4.full_head", {24'b0, sample_data}, 32'h71);
    slave_val = 32'h77;
    wait_read("t4.p5");
    step();
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    enable = 1'b0;
    chk("t4.no_overflow", {31'b0, overflow}, 32'd0);
    chk("t4.head_after", {24'b0, sample_data}, 32'h72);
    sample_ready = 1'b1;
    step();
    chk("t4.drain73", {24'b0, sample_data}, 32'h73);
    step();
    chk("t4.drain74", {24'b0, sample_data}, 32'h74);
    step();
    chk("t4.drain77", {24'b0, sample_data}, 32'h77);
    step();
    chk("t4.empty", {31'b0, sample_valid}, 32'd0);
    sample_ready = 1'b0;

    // Test 4b: clear_overflow coinciding with a drop leaves the flag set.
    enable = 1'b1;
    do_poll(32'h81, "t4b.p1");
    do_poll(32'h82, "t4b.p2");
    do_poll(32'h83, "t4b.p3");
    do_poll(32'h84, "t4b.p4");
    slave_val = 32'h85;
    wait_read("t4b.p5");
    step();
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("t4b.set_wins", {31'b0, overflow}, 32'd1);
    chk("t4b.contents_kept", {24'b0, sample_data}, 32'h81);
    enable = 1'b0;
    sample_ready = 1'b1;
    repeat (4) step();
    sample_ready = 1'b0;
    chk("t4b.drained", {31'b0, sample_valid}, 32'd0);

    // Test 5: enable dropped during the read cycle.
    enable = 1'b1;
    slave_val = 32'h55;
    wait_read("t5.p1");
    enable = 1'b0;
    step();
    step();
    chk("t5.valid", {31'b0, sample_valid}, 32'd1);
    chk("t5.data", {24'b0, sample_data}, 32'h55);
    nr = 0;
    repeat (12) begin
      step();
      if (avm_read) nr++;
    end
    chk("t5.no_read_disabled", nr, 32'd0);
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!avm_read && n < 20);
    chk("t5.reenable_latency", n, 32'd4);
    step();
    step();

    // Test 6: reset during CAPT with two entries queued.
    do_poll(32'h61, "t6.p1");
    slave_val = 32'h62;
    wait_read("t6.p2");
    step();
    reset = 1'b1;
    #2;
    chk("t6.read", {31'b0, avm_read}, 32'd0);
    chk("t6.valid", {31'b0, sample_valid}, 32'd0);
    chk("t6.overflow", {31'b0, overflow}, 32'd0);
    step();
    reset = 1'b0;
    do_poll(32'h00, "t6.p3");
    chk("t6.first_pushed", {31'b0, sample_valid}, 32'd1);
    chk("t6.first_data", {24'b0, sample_data}, 32'h00);
    do_poll(32'h00, "t6.p4");
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("t6.repeat_filtered", {31'b0, sample_valid}, 32'd0);

    // Reset in the READ cycle drops the strobe without a clock edge.
    slave_val = 32'h99;
    wait_read("t6.p5");
    reset = 1'b1;
    #2;
    chk("t6.async_read_drop", {31'b0, avm_read}, 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
